// File: rtl/vcve2_dmem_arb_pkg.sv
// Shared types and width helpers for the data-memory multi-port arbiter.
package vcve2_dmem_arb_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int PerfCntWidth = 16;

  // Index width that never collapses to zero bits, so 1- and 2-entry sizes still get a real bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vcve2_id_fifo.sv
// In-order FIFO of small IDs; any depth, pointers wrap modulo Depth.
module vcve2_id_fifo
  import vcve2_dmem_arb_pkg::*;
#(
  parameter int Width = 1,
  parameter int Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       i_push,
  input  logic [Width-1:0]           i_data,
  input  logic                       i_pop,
  output logic [Width-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(Depth+1)-1:0] o_count
);

  localparam int PtrW = clog2_min1(Depth);
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_rptr;
  logic [PtrW-1:0]  r_wptr;
  logic [CntW-1:0]  r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CntW'(Depth));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rptr];
  // A full FIFO never accepts a push, even when a pop happens in the same cycle.
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk_i) begin
    if (w_push_ok) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= ptr_inc(r_wptr);
      if (w_pop_ok)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/vcve2_dmem_mp_arbiter.sv
// N-port OBI data-memory arbiter with in-order response steering, stall hold and bus lock.
// Define VCVE2_DMEM_ARB_PERF_EN to add per-port saturating stall counters (perf_stall_cnt_o).
module vcve2_dmem_mp_arbiter
  import vcve2_dmem_arb_pkg::*;
#(
  parameter int NumPorts       = 2,
  parameter int MaxOutstanding = 2,
  parameter bit RoundRobin     = 1'b0,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumPorts-1:0]                  port_req_i,
  input  logic [NumPorts-1:0]                  port_lock_i,
  input  logic [NumPorts-1:0]                  port_we_i,
  input  logic [NumPorts*DataWidth/8-1:0]      port_be_i,
  input  logic [NumPorts*AddrWidth-1:0]        port_addr_i,
  input  logic [NumPorts*DataWidth-1:0]        port_wdata_i,
  output logic [NumPorts-1:0]                  port_gnt_o,
  output logic [NumPorts-1:0]                  port_rvalid_o,
  output logic [NumPorts-1:0]                  port_err_o,
  output logic [DataWidth-1:0]                 port_rdata_o,
  output logic                                 data_req_o,
  input  logic                                 data_gnt_i,
  output logic                                 data_we_o,
  output logic [DataWidth/8-1:0]               data_be_o,
  output logic [AddrWidth-1:0]                 data_addr_o,
  output logic [DataWidth-1:0]                 data_wdata_o,
  input  logic                                 data_rvalid_i,
  input  logic [DataWidth-1:0]                 data_rdata_i,
  input  logic                                 data_err_i,
  output logic                                 spurious_rsp_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]  outstanding_o
`ifdef VCVE2_DMEM_ARB_PERF_EN
  ,
  output logic [NumPorts*PerfCntWidth-1:0]     perf_stall_cnt_o
`endif
);

  localparam int        IdW     = clog2_min1(NumPorts);
  localparam int        BeW     = DataWidth / 8;
  localparam arb_mode_e ArbMode = RoundRobin ? ARB_RR : ARB_FIXED;

  // Handshake: a transfer happens in a cycle where data_req_o && data_gnt_i; the
  // request fields must stay stable until then, so a stalled winner is held.
  logic [IdW-1:0] r_rr_ptr;
  logic [IdW-1:0] r_stall_owner;
  logic           r_stall_valid;
  logic [IdW-1:0] r_lock_owner;
  logic           r_lock_valid;
  logic           r_spurious;

  logic [IdW-1:0] w_arb_idx;
  logic           w_arb_found;
  logic           w_stall_hold;
  logic [IdW-1:0] w_win;
  logic           w_win_req;
  logic           w_hs;
  logic [IdW-1:0] w_rr_next;
  logic           w_fifo_full;
  logic           w_fifo_empty;
  logic           w_pop;
  logic [IdW-1:0] w_head;

  always_comb begin
    int idx;
    w_arb_found = 1'b0;
    w_arb_idx   = '0;
    for (int i = 0; i < NumPorts; i++) begin
      idx = (ArbMode == ARB_RR) ? (int'(r_rr_ptr) + i) % NumPorts : i;
      if (!w_arb_found && port_req_i[idx]) begin
        w_arb_found = 1'b1;
        w_arb_idx   = IdW'(idx);
      end
    end
  end

  // The stalled owner keeps precedence only while it still asks for the bus.
  assign w_stall_hold = r_stall_valid && port_req_i[r_stall_owner];

  always_comb begin
    if (r_lock_valid)      w_win = r_lock_owner;
    else if (w_stall_hold) w_win = r_stall_owner;
    else                   w_win = w_arb_idx;
  end

  assign w_win_req    = port_req_i[w_win];
  assign data_req_o   = w_win_req && !w_fifo_full;
  assign w_hs         = data_req_o && data_gnt_i;
  assign w_rr_next    = (w_win == IdW'(NumPorts - 1)) ? '0 : w_win + 1'b1;
  assign w_pop        = data_rvalid_i && !w_fifo_empty;

  assign data_we_o    = port_we_i[w_win];
  assign data_be_o    = port_be_i[w_win*BeW +: BeW];
  assign data_addr_o  = port_addr_i[w_win*AddrWidth +: AddrWidth];
  assign data_wdata_o = port_wdata_i[w_win*DataWidth +: DataWidth];
  assign port_rdata_o = data_rdata_i;
  assign spurious_rsp_o = r_spurious;

  always_comb begin
    port_gnt_o    = '0;
    port_rvalid_o = '0;
    port_err_o    = '0;
    if (w_hs) port_gnt_o[w_win] = 1'b1;
    if (w_pop) begin
      port_rvalid_o[w_head] = 1'b1;
      port_err_o[w_head]    = data_err_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr      <= '0;
      r_stall_owner <= '0;
      r_stall_valid <= 1'b0;
      r_lock_owner  <= '0;
      r_lock_valid  <= 1'b0;
      r_spurious    <= 1'b0;
    end else begin
      if (w_hs) begin
        r_stall_valid <= 1'b0;
        if (!(r_lock_valid || port_lock_i[w_win])) r_rr_ptr <= w_rr_next;
      end else if (w_win_req) begin
        r_stall_valid <= 1'b1;
        r_stall_owner <= w_win;
      end else begin
        r_stall_valid <= 1'b0;
      end

      if (r_lock_valid) begin
        if (!port_lock_i[r_lock_owner]) r_lock_valid <= 1'b0;
      end else if (w_hs && port_lock_i[w_win]) begin
        r_lock_valid <= 1'b1;
        r_lock_owner <= w_win;
      end

      if (data_rvalid_i && w_fifo_empty) r_spurious <= 1'b1;
    end
  end

  vcve2_id_fifo #(
    .Width (IdW),
    .Depth (MaxOutstanding)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_hs),
    .i_data  (w_win),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (outstanding_o)
  );

`ifdef VCVE2_DMEM_ARB_PERF_EN
  for (genvar k = 0; k < NumPorts; k++) begin : g_perf
    logic [PerfCntWidth-1:0] r_cnt;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_cnt <= '0;
      else if (port_req_i[k] && !port_gnt_o[k] && (r_cnt != '1)) r_cnt <= r_cnt + 1'b1;
    end
    assign perf_stall_cnt_o[k*PerfCntWidth +: PerfCntWidth] = r_cnt;
  end
`endif

endmodule
